// File: rtl/nes_bus_arb.sv
// nes_bus_arb: N-master to single-slave bus arbiter with fixed or round-robin priority,
// preemption, a drain phase and read-return routing through an issuer tag pipeline.
module nes_bus_arb #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 1,
    parameter int RR_MODE     = 0,
    parameter logic [NUM_MASTERS-1:0] PREEMPT_MASK = NUM_MASTERS'(2'b10)
) (
    input  logic                          clk_in,
    input  logic                          nres_in,
    input  logic [NUM_MASTERS-1:0]        m_req_in,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_a_in,
    input  logic [NUM_MASTERS-1:0]        m_r_nw_in,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_d_in,
    output logic [NUM_MASTERS-1:0]        m_gnt_out,
    output logic [NUM_MASTERS-1:0]        m_dvalid_out,
    output logic [DATA_W-1:0]             m_d_out,
    output logic                          s_en_out,
    output logic [ADDR_W-1:0]             s_a_out,
    output logic                          s_r_nw_out,
    output logic [DATA_W-1:0]             s_d_out,
    input  logic [DATA_W-1:0]             s_d_in,
    output logic                          busy_out
);
    localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]          r_own, w_own_nxt, r_last, w_last_nxt, w_win;
    logic [1:0]             r_cnt, w_cnt_nxt;
    logic [NUM_MASTERS-1:0] r_dv, w_tag, w_ret;
    logic [DATA_W-1:0]      r_dout;
    logic                   w_own_req, w_preempt, w_beat;

    // Candidate examined k-th; the loop runs backwards so the first candidate wins.
    function automatic int pick(input int k, input int last);
        return RR_MODE != 0 ? (last + 1 + k) % NUM_MASTERS : NUM_MASTERS - 1 - k;
    endfunction

    always_comb begin
        w_win = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
            if (m_req_in[IW'(pick(k, int'(r_last)))]) w_win = IW'(pick(k, int'(r_last)));
    end

    assign w_own_req = |(r_gnt & m_req_in);
    assign w_preempt = |(m_req_in & PREEMPT_MASK & ~r_gnt);
    assign w_beat    = (r_state == OWN) && w_own_req;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (|m_req_in) begin
                w_state_nxt = OWN;
                w_gnt_nxt   = NUM_MASTERS'(1) << w_win;
                w_own_nxt   = w_win;
            end
            OWN: if (!w_own_req || w_preempt) begin
                w_state_nxt = RD_LAT == 0 ? IDLE : DRAIN;
                w_gnt_nxt   = '0;
                w_last_nxt  = r_own;
                w_cnt_nxt   = 2'(RD_LAT - 1);
            end
            DRAIN: if (r_cnt == 2'd0) w_state_nxt = IDLE; else w_cnt_nxt = r_cnt - 2'd1;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!nres_in) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_own   <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign s_en_out   = w_beat;
    assign s_a_out    = w_beat ? m_a_in[r_own*ADDR_W +: ADDR_W] : '0;
    assign s_r_nw_out = w_beat ? m_r_nw_in[r_own] : 1'b1;
    assign s_d_out    = w_beat ? m_d_in[r_own*DATA_W +: DATA_W] : '0;
    assign busy_out   = r_state != IDLE;
    assign m_gnt_out  = r_gnt;

    // Issuer tag travels with each read so returns stay routed after the grant moves on.
    assign w_tag = (w_beat && m_r_nw_in[r_own]) ? r_gnt : '0;

    generate
        if (RD_LAT == 0) begin : g_direct
            assign w_ret = w_tag;
        end else begin : g_pipe
            logic [NUM_MASTERS-1:0] r_tag [RD_LAT];
            always_ff @(posedge clk_in) begin
                if (!nres_in) begin
                    r_tag <= '{default: '0};
                end else begin
                    r_tag[0] <= w_tag;
                    for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
                end
            end
            assign w_ret = r_tag[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (!nres_in) begin
            r_dv   <= '0;
            r_dout <= '0;
        end else begin
            r_dv <= w_ret;
            if (|w_ret) r_dout <= s_d_in;
        end
    end

    assign m_dvalid_out = r_dv;
    assign m_d_out      = r_dout;
endmodule

// File: tb/tb_nes_bus_arb.sv
// tb_nes_bus_arb: scoreboard bench for nes_bus_arb (default, round-robin and zero-latency builds).
module tb_nes_bus_arb;
    logic clk = 1'b0;
    logic nres = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    // default build
    logic [1:0]  d_req = '0, d_rnw = '0, d_gnt, d_dv;
    logic [31:0] d_a = '0;
    logic [15:0] d_d = '0, d_sa;
    logic [7:0]  d_dout, d_sd, d_sdi = '0;
    logic        d_en, d_srnw, d_busy;

    nes_bus_arb u_def (
        .clk_in(clk), .nres_in(nres), .m_req_in(d_req), .m_a_in(d_a), .m_r_nw_in(d_rnw),
        .m_d_in(d_d), .m_gnt_out(d_gnt), .m_dvalid_out(d_dv), .m_d_out(d_dout),
        .s_en_out(d_en), .s_a_out(d_sa), .s_r_nw_out(d_srnw), .s_d_out(d_sd),
        .s_d_in(d_sdi), .busy_out(d_busy)
    );

    // one-cycle-latency slave: data valid only in the cycle after the read beat
    always @(posedge clk) d_sdi <= (d_en && d_srnw) ? f(d_sa) : 8'h00;

    // round-robin build, no preemption
    logic [1:0]  r_req = '0, r_rnw = '0, r_gnt, r_dv;
    logic [31:0] r_a = '0;
    logic [15:0] r_d = '0, r_sa;
    logic [7:0]  r_dout, r_sd, r_sdi = '0;
    logic        r_en, r_srnw, r_busy;

    nes_bus_arb #(.RR_MODE(1), .PREEMPT_MASK(2'b00)) u_rr (
        .clk_in(clk), .nres_in(nres), .m_req_in(r_req), .m_a_in(r_a), .m_r_nw_in(r_rnw),
        .m_d_in(r_d), .m_gnt_out(r_gnt), .m_dvalid_out(r_dv), .m_d_out(r_dout),
        .s_en_out(r_en), .s_a_out(r_sa), .s_r_nw_out(r_srnw), .s_d_out(r_sd),
        .s_d_in(r_sdi), .busy_out(r_busy)
    );

    // zero read latency build
    logic [1:0]  z_req = '0, z_rnw = '0, z_gnt, z_dv;
    logic [31:0] z_a = '0;
    logic [15:0] z_d = '0, z_sa;
    logic [7:0]  z_dout, z_sd, z_sdi;
    logic        z_en, z_srnw, z_busy;

    nes_bus_arb #(.RD_LAT(0)) u_l0 (
        .clk_in(clk), .nres_in(nres), .m_req_in(z_req), .m_a_in(z_a), .m_r_nw_in(z_rnw),
        .m_d_in(z_d), .m_gnt_out(z_gnt), .m_dvalid_out(z_dv), .m_d_out(z_dout),
        .s_en_out(z_en), .s_a_out(z_sa), .s_r_nw_out(z_srnw), .s_d_out(z_sd),
        .s_d_in(z_sdi), .busy_out(z_busy)
    );

    assign z_sdi = (z_en && z_srnw) ? f(z_sa) : 8'h00;

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    always @(negedge clk) begin
        if (d_dv != 2'b00) begin
            if (sb_q.size() == 0) begin
                chk("dv_spurious", 32'(d_dv), 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("dv_who", 32'(d_dv), 32'(e.who));
                chk("dv_data", 32'(d_dout), 32'(e.data));
            end
        end
    end

    initial begin
        repeat (3) cyc;
        chk("rst_gnt", 32'(d_gnt), 32'h0);
        chk("rst_dv", 32'(d_dv), 32'h0);
        chk("rst_dout", 32'(d_dout), 32'h0);
        chk("rst_en", 32'(d_en), 32'h0);
        chk("rst_busy", 32'(d_busy), 32'h0);
        chk("rst_sa", 32'(d_sa), 32'h0);
        chk("rst_srnw", 32'(d_srnw), 32'h1);
        chk("rst_sd", 32'(d_sd), 32'h0);
        chk("rst_rr_busy", 32'(r_busy), 32'h0);
        chk("rst_l0_gnt", 32'(z_gnt), 32'h0);
        nres = 1'b1;

        // single read from master 0
        cyc;
        d_req = 2'b01; d_a[15:0] = 16'h0123; d_rnw = 2'b01;
        sb_q.push_back('{who: 2'b01, data: 8'h5A});
        #1 chk("r1_nognt", 32'(d_gnt), 32'h0);
        cyc;
        #1 chk("r1_gnt", 32'(d_gnt), 32'h1);
        chk("r1_en", 32'(d_en), 32'h1);
        chk("r1_sa", 32'(d_sa), 32'h0123);
        cyc;
        d_req = 2'b00;
        #1 chk("r1_rel_en", 32'(d_en), 32'h0);
        cyc;
        #1 chk("r1_dv", 32'(d_dv), 32'h1);
        chk("r1_dout", 32'(d_dout), 32'h5A);
        chk("r1_drain_gnt", 32'(d_gnt), 32'h0);
        chk("r1_drain_busy", 32'(d_busy), 32'h1);
        cyc;
        #1 chk("r1_idle_busy", 32'(d_busy), 32'h0);
        chk("r1_hold", 32'(d_dout), 32'h5A);

        // four reads from master 0, preempted by master 1 which then writes once
        d_req = 2'b01;
        d_a[31:16] = 16'h07FF; d_d[15:8] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            cyc;
            d_a[15:0] = 16'(k);
            sb_q.push_back('{who: 2'b01, data: f(16'(k))});
            if (k == 3) d_req[1] = 1'b1;
            #1 chk("pre_gnt", 32'(d_gnt), 32'h1);
            chk("pre_en", 32'(d_en), 32'h1);
        end
        cyc;
        d_req[0] = 1'b0;
        #1 chk("pre_clr", 32'(d_gnt), 32'h0);
        chk("pre_drain", 32'(d_busy), 32'h1);
        chk("pre_drain_en", 32'(d_en), 32'h0);
        cyc;
        #1 chk("pre_idle", 32'(d_busy), 32'h0);
        cyc;
        #1 chk("wr_gnt", 32'(d_gnt), 32'h2);
        chk("wr_en", 32'(d_en), 32'h1);
        chk("wr_sa", 32'(d_sa), 32'h07FF);
        chk("wr_srnw", 32'(d_srnw), 32'h0);
        chk("wr_sd", 32'(d_sd), 32'hA5);
        cyc;
        d_req = 2'b00;
        #1 chk("wr_end_en", 32'(d_en), 32'h0);
        chk("wr_end_sd", 32'(d_sd), 32'h0);
        chk("wr_end_srnw", 32'(d_srnw), 32'h1);
        repeat (4) cyc;
        chk("sb_drained1", 32'(sb_q.size()), 32'h0);

        // reset with a read outstanding
        d_req = 2'b01; d_a[15:0] = 16'h0042; d_rnw = 2'b01;
        cyc;
        #1 chk("rr_gnt", 32'(d_gnt), 32'h1);
        chk("rr_en", 32'(d_en), 32'h1);
        cyc;
        nres = 1'b0; d_req = 2'b00;
        cyc;
        nres = 1'b1;
        #1 chk("rr_gnt0", 32'(d_gnt), 32'h0);
        chk("rr_dv0", 32'(d_dv), 32'h0);
        chk("rr_dout0", 32'(d_dout), 32'h0);
        chk("rr_busy0", 32'(d_busy), 32'h0);
        chk("rr_en0", 32'(d_en), 32'h0);
        d_req = 2'b10; d_a[31:16] = 16'h0200; d_rnw = 2'b10;
        sb_q.push_back('{who: 2'b10, data: f(16'h0200)});
        cyc;
        #1 chk("rr_fresh_gnt", 32'(d_gnt), 32'h2);
        chk("rr_fresh_en", 32'(d_en), 32'h1);
        cyc;
        d_req = 2'b00;
        repeat (4) cyc;
        chk("sb_drained2", 32'(sb_q.size()), 32'h0);

        // round-robin alternation
        r_req = 2'b11;
        cyc;
        #1 chk("rrm_g1", 32'(r_gnt), 32'h1);
        cyc;
        cyc;
        r_req = 2'b10;
        #1 chk("rrm_rel_hold", 32'(r_gnt), 32'h1);
        chk("rrm_rel_en", 32'(r_en), 32'h0);
        cyc;
        r_req = 2'b11;
        #1 chk("rrm_drain1", 32'(r_gnt), 32'h0);
        chk("rrm_drain1_busy", 32'(r_busy), 32'h1);
        cyc;
        #1 chk("rrm_idle1", 32'(r_busy), 32'h0);
        cyc;
        #1 chk("rrm_g2", 32'(r_gnt), 32'h2);
        cyc;
        cyc;
        r_req = 2'b01;
        cyc;
        r_req = 2'b11;
        #1 chk("rrm_drain2", 32'(r_gnt), 32'h0);
        cyc;
        cyc;
        #1 chk("rrm_g3", 32'(r_gnt), 32'h1);
        r_req = 2'b00;

        // zero latency: release and preempt request together
        cyc;
        z_req = 2'b01; z_a[15:0] = 16'h0123; z_rnw = 2'b01;
        cyc;
        #1 chk("l0_gnt", 32'(z_gnt), 32'h1);
        chk("l0_en", 32'(z_en), 32'h1);
        cyc;
        z_req = 2'b10;
        #1 chk("l0_dv", 32'(z_dv), 32'h1);
        chk("l0_dout", 32'(z_dout), 32'h5A);
        chk("l0_rel_en", 32'(z_en), 32'h0);
        cyc;
        #1 chk("l0_idle_gnt", 32'(z_gnt), 32'h0);
        chk("l0_idle_busy", 32'(z_busy), 32'h0);
        chk("l0_dv_once", 32'(z_dv), 32'h0);
        cyc;
        #1 chk("l0_g2", 32'(z_gnt), 32'h2);
        z_req = 2'b00;
        repeat (3) cyc;

        chk("sb_final", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
